clk_period_meter: RTL and testbench
===================================

// Module: clk_period_meter
// PURPOSE
//  Measures an incoming slow clock/square wave (e.g. divider output, external tick) against clkin.
//  Reports period and high time in clkin cycles, with a one-cycle valid pulse per completed period.
//  Flags loss of signal via timeout.
//  Sits beside clock generation logic for self-check and frequency readback to the CPU/display.
// PARAMETERS
//  IN_CLK_FRQ   1000000     clkin frequency in Hz; sets the default timeout
//  CNT_WIDTH    32          width of cycle counter and result outputs
//  TIMEOUT_CYC  IN_CLK_FRQ  cycles with no rising edge before timeout (1 s at default); must be < 2^CNT_WIDTH
//  SYNC_STAGES  2           synchronizer flops on sigin (>= 2)
// PORTS
//  clkin      in   1          system clock, all logic on posedge
//  reset      in   1          asynchronous, active-high reset
//  sigin      in   1          asynchronous signal to measure
//  period     out  CNT_WIDTH  last measured rise-to-rise distance, in clkin cycles
//  high_time  out  CNT_WIDTH  last measured rise-to-fall distance, in clkin cycles
//  valid      out  1          1-cycle pulse when period/high_time are updated
//  locked     out  1          1 once a full period is measured; 0 after timeout or reset
//  timeout    out  1          sticky; set on timeout, cleared on the next rising edge
// BEHAVIOUR
//  Reset (async assert, sampled deassert): period=0, high_time=0, valid=0, locked=0, timeout=0.
//    Reset also clears sync flops, edge history, counter (cnt=0) and state=S_WAIT.
//  Synchronization and edge detection:
//    sigin passes through SYNC_STAGES flops; s = last stage, s_d = s delayed by 1 cycle.
//    rise = s & ~s_d; fall = ~s & s_d.
//    Latency from a sigin transition to rise/fall: SYNC_STAGES+1 cycles.
//    High or low phases shorter than 1 clkin cycle may be lost; not required to be detected.
//  Counter cnt:
//    Loaded with 1 on rise.
//    Otherwise increments every cycle in S_MEAS, saturating at all-ones.
//    Value on a later cycle t = t - t_rise.
//  FSM states:
//   S_WAIT: cnt held at 0.
//     On rise -> S_MEAS, cnt<=1, timeout<=0. Outputs are not updated. fall is ignored.
//   S_MEAS:
//     On fall: hi_cap<=cnt (internal register).
//     On rise: period<=cnt, high_time<=hi_cap, valid<=1 next cycle, locked<=1, cnt<=1.
//     When cnt==TIMEOUT_CYC and no rise this cycle -> S_WAIT: timeout<=1, locked<=0, cnt<=0.
//       period and high_time hold their last values.
//  valid:
//    Registered, high exactly 1 cycle, in the cycle after the rise that closes the period.
//    period and high_time change in that same cycle and are stable until the next valid.
//  Simultaneous rise and cnt==TIMEOUT_CYC: rise wins (measure period=TIMEOUT_CYC, stay in S_MEAS).
//  A period with no fall seen (sigin never went low) reports high_time from the previous period.
//  Reset mid-measurement: everything returns to reset values; the first valid needs two new rises.
// STRUCTURE
//  Shared header/package: state encodings S_WAIT, S_MEAS; default CNT_WIDTH.
//  Sub-module sync_edge_detect (params SYNC_STAGES):
//    ports clkin, reset, din -> dsync, rise, fall.
//    Reusable for buttons and other external inputs.
//  Top: FSM, counter, capture registers.
// TESTING (bench params: IN_CLK_FRQ=1000, TIMEOUT_CYC=100, CNT_WIDTH=16)
//  1. sigin square wave, 10 cycles high / 10 low:
//     no valid after the first rise; valid after the 2nd rise with period=20, high_time=10, locked=1.
//  2. Switch to 3 high / 7 low mid-stream:
//     first new period may be mixed; from the next one on, period=10, high_time=3, valid every 10 cycles.
//  3. Hold sigin low after a rise:
//     100 cycles after the synced rise, timeout=1, locked=0, period unchanged.
//     Next rise clears timeout; no valid until a second rise.
//  4. sigin toggles every clkin cycle (period 2):
//     period=2, high_time=1, valid every 2 cycles.
//  5. Assert reset for 3 cycles mid-period, async to clkin:
//     outputs go to 0 immediately; after release, the first valid comes on the 2nd rise with correct values.
//  6. Rise arriving exactly at cnt==100:
//     period=100, valid=1, timeout stays 0, locked stays 1.

Source files
------------

// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// the default counter width.
package clk_period_meter_pkg;

    // Default width of the cycle counter and of the period/high_time results.
    localparam int DEFAULT_CNT_WIDTH = 32;

    // Measurement FSM states.
    //   S_WAIT : no reference edge yet (after reset or after a timeout)
    //   S_MEAS : counting from the last rising edge
    typedef enum logic {
        S_WAIT = 1'b0,
        S_MEAS = 1'b1
    } meas_state_t;

endpackage

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Synchronizes an asynchronous input into the clkin domain and produces
// single-cycle rise/fall strobes from the synchronized level. Usable for
// buttons and other external inputs as well as the period meter.
module clk_period_meter_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic reset,
    input  logic din,
    output logic dsync,
    output logic rise,
    output logic fall
);

    // Synchronizer chain; bit 0 is the metastability-exposed flop.
    logic [SYNC_STAGES-1:0] sync_q;
    // Synchronized level delayed by one cycle, for edge detection.
    logic                   dsync_p1;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Keep one cycle of edge history on the synchronized level.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            dsync_p1 <= 1'b0;
        end else begin
            dsync_p1 <= dsync;
        end
    end

    assign dsync = sync_q[SYNC_STAGES-1];
    assign rise  = dsync & ~dsync_p1;
    assign fall  = ~dsync & dsync_p1;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow asynchronous signal in clkin
// cycles. A one-cycle valid pulse marks each completed period; a timeout
// flags loss of signal when no rising edge arrives within TIMEOUT_CYC cycles.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int IN_CLK_FRQ  = 1000000,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int TIMEOUT_CYC = IN_CLK_FRQ,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clkin,
    input  logic                 reset,
    input  logic                 sigin,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 locked,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYC);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    // Counter increment that sticks at all-ones instead of wrapping, so a
    // very large TIMEOUT_CYC can never alias back to a small count.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    meas_state_t          state;
    meas_state_t          state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] hi_cap;

    // Only the edge strobes drive the measurement; the level itself is spare.
    logic                 sync_level_unused;
    logic                 rise;
    logic                 fall;

    logic                 in_meas;
    logic                 at_limit;
    logic                 close_period;
    logic                 lose_signal;

    clk_period_meter_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clkin (clkin),
        .reset (reset),
        .din   (sigin),
        .dsync (sync_level_unused),
        .rise  (rise),
        .fall  (fall)
    );

    assign in_meas      = (state == S_MEAS);
    assign at_limit     = (cnt == TIMEOUT_VAL);
    // A rise always closes the period, even on the cycle the limit is hit.
    assign close_period = in_meas & rise;
    assign lose_signal  = in_meas & ~rise & at_limit;

    // FSM state register.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: arm on the first rise, fall back to waiting on timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_WAIT: begin
                if (rise) begin
                    state_nxt = S_MEAS;
                end
            end
            S_MEAS: begin
                if (lose_signal) begin
                    state_nxt = S_WAIT;
                end
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // Cycle counter: restarts at 1 on every rise, runs while measuring.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (!in_meas || lose_signal) begin
            cnt <= '0;
        end else begin
            cnt <= sat_inc(cnt);
        end
    end

    // High-time capture on fall, result capture on the rise closing a period.
    // hi_cap is only overwritten by a fall, so a period without a low phase
    // reports the previous high time.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            hi_cap    <= '0;
            period    <= '0;
            high_time <= '0;
        end else begin
            if (in_meas && fall) begin
                hi_cap <= cnt;
            end
            if (close_period) begin
                period    <= cnt;
                high_time <= hi_cap;
            end
        end
    end

    // Status flags: valid strobe, lock indication and sticky timeout.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= close_period;
            if (close_period) begin
                locked <= 1'b1;
            end else if (lose_signal) begin
                locked <= 1'b0;
            end
            if (lose_signal) begin
                timeout <= 1'b1;
            end else if (!in_meas && rise) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with IN_CLK_FRQ=1000, TIMEOUT_CYC=100,
// CNT_WIDTH=16. sigin is driven 2 ns after each clkin rising edge, so every
// rise-to-rise distance in drive cycles equals the expected period.
module tb_clk_period_meter;

    localparam int CW = 16;
    localparam int TO = 100;

    logic          clkin = 1'b0;
    logic          reset = 1'b1;
    logic          sigin = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          locked;
    logic          timeout;

    clk_period_meter #(
        .IN_CLK_FRQ  (1000),
        .CNT_WIDTH   (CW),
        .TIMEOUT_CYC (TO),
        .SYNC_STAGES (2)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .sigin     (sigin),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;

    int   cyc       = 0;
    int   vcount    = 0;
    int   last_vcyc = 0;
    int   prev_vcyc = 0;
    int   last_p    = 0;
    int   last_h    = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_p;
        int exp_h;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            sigin = v;
            @(posedge clkin);
            #2;
        end
    endtask

    // Record every valid pulse 1 ns after the edge: time, results, width.
    always @(posedge clkin) begin
        #1;
        cyc++;
        if (valid === 1'b1) begin
            chk("valid_single_cycle", int'(prev_valid), 0);
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
            vcount++;
            last_p = int'(period);
            last_h = int'(high_time);
        end
        prev_valid = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0;
        int p_before;
        int h_before;

        vecs[0] = '{hi: 10, lo: 10, reps: 6, exp_p: 20, exp_h: 10};
        vecs[1] = '{hi: 3,  lo: 7,  reps: 6, exp_p: 10, exp_h: 3};
        vecs[2] = '{hi: 1,  lo: 1,  reps: 6, exp_p: 2,  exp_h: 1};
        vecs[3] = '{hi: 5,  lo: 15, reps: 6, exp_p: 20, exp_h: 5};
        vecs[4] = '{hi: 50, lo: 30, reps: 4, exp_p: 80, exp_h: 50};

        // Reset state
        repeat (3) @(posedge clkin);
        #2;
        chk("rst_period",    int'(period),    0);
        chk("rst_high_time", int'(high_time), 0);
        chk("rst_valid",     int'(valid),     0);
        chk("rst_locked",    int'(locked),    0);
        chk("rst_timeout",   int'(timeout),   0);
        reset = 1'b0;
        drive(1'b0, 3);

        // First rise only arms the meter; the second closes a 20-cycle period
        drive(1'b1, 10);
        drive(1'b0, 10);
        chk("t1_no_valid_first_rise", vcount, 0);
        chk("t1_not_locked_yet", int'(locked), 0);
        drive(1'b1, 10);
        chk("t1_one_valid", vcount, 1);
        chk("t1_period", last_p, 20);
        chk("t1_high_time", last_h, 10);
        chk("t1_locked", int'(locked), 1);
        drive(1'b0, 10);

        // Table of square waves, each continuing from the previous pattern
        for (int i = 0; i < 5; i++) begin
            v0 = vcount;
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(1'b1, vecs[i].hi);
                drive(1'b0, vecs[i].lo);
            end
            chk($sformatf("vec%0d_period", i), last_p, vecs[i].exp_p);
            chk($sformatf("vec%0d_high_time", i), last_h, vecs[i].exp_h);
            chk($sformatf("vec%0d_spacing", i), last_vcyc - prev_vcyc, vecs[i].exp_p);
            chk($sformatf("vec%0d_locked", i), int'(locked), 1);
            chk($sformatf("vec%0d_timeout", i), int'(timeout), 0);
            chk($sformatf("vec%0d_valid_count_ok", i),
                int'((vcount - v0) >= (vecs[i].reps - 2)), 1);
        end

        // Loss of signal: rise, then low forever; timeout 102 edges after drive
        drive(1'b1, 5);
        chk("t3_last_period", last_p, 80);
        p_before = int'(period);
        h_before = int'(high_time);
        drive(1'b0, 97);
        chk("t3_timeout_not_yet", int'(timeout), 0);
        chk("t3_locked_not_yet", int'(locked), 1);
        drive(1'b0, 1);
        chk("t3_timeout_set", int'(timeout), 1);
        chk("t3_locked_cleared", int'(locked), 0);
        chk("t3_period_held", int'(period), p_before);
        chk("t3_high_time_held", int'(high_time), h_before);
        v0 = vcount;
        drive(1'b1, 3);
        chk("t3_timeout_cleared_by_rise", int'(timeout), 0);
        chk("t3_still_unlocked", int'(locked), 0);
        chk("t3_no_valid_on_first_rise", vcount, v0);
        drive(1'b1, 7);
        drive(1'b0, 10);
        drive(1'b1, 5);
        chk("t3_relock_valid", vcount, v0 + 1);
        chk("t3_relock_period", last_p, 20);
        chk("t3_relock_high_time", last_h, 10);
        chk("t3_relock_locked", int'(locked), 1);

        // Rise coinciding with cnt==TIMEOUT_CYC: period 100, no timeout
        drive(1'b1, 5);
        drive(1'b0, 90);
        drive(1'b1, 5);
        chk("t6_valid", vcount, v0 + 2);
        chk("t6_period_100", last_p, 100);
        chk("t6_high_time", last_h, 10);
        chk("t6_timeout_stays_0", int'(timeout), 0);
        chk("t6_locked_stays_1", int'(locked), 1);

        // One cycle longer (period 101): timeout fires just before the rise
        v0 = vcount;
        drive(1'b1, 5);
        drive(1'b0, 91);
        drive(1'b1, 2);
        chk("t6b_timeout_set", int'(timeout), 1);
        chk("t6b_locked_cleared", int'(locked), 0);
        drive(1'b1, 1);
        chk("t6b_timeout_cleared", int'(timeout), 0);
        chk("t6b_no_valid", vcount, v0);

        // Relock, then async reset mid-period
        drive(1'b1, 7);
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 10);
        chk("t5_pre_period", last_p, 20);
        drive(1'b1, 4);
        chk("t5_pre_locked", int'(locked), 1);
        #3;
        reset = 1'b1;
        sigin = 1'b0;
        #1;
        chk("t5_async_period",    int'(period),    0);
        chk("t5_async_high_time", int'(high_time), 0);
        chk("t5_async_valid",     int'(valid),     0);
        chk("t5_async_locked",    int'(locked),    0);
        chk("t5_async_timeout",   int'(timeout),   0);
        repeat (3) @(posedge clkin);
        #2;
        reset = 1'b0;
        v0 = vcount;
        drive(1'b0, 2);
        drive(1'b1, 10);
        drive(1'b0, 10);
        chk("t5_no_valid_first_rise", vcount, v0);
        chk("t5_not_locked", int'(locked), 0);
        drive(1'b1, 5);
        chk("t5_valid_second_rise", vcount, v0 + 1);
        chk("t5_period", last_p, 20);
        chk("t5_high_time", last_h, 10);
        chk("t5_locked", int'(locked), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
